if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/spu_if_pkg.sv | 15 +
 rtl/if_instr_mem.sv | 29 ++
 rtl/if_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_if_pkg.sv
// rtl/spu_if_pkg.sv - shared constants and state type for the instruction fetch unit
package spu_if_pkg;

  localparam int INSTR_W_DEF = 32;

  // Filler for lanes that carry no real instruction (addi x0,x0,0).
  localparam logic [INSTR_W_DEF-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_instr_mem.sv
// rtl/if_instr_mem.sv - instruction buffer, one write port and ISSUE_W combinational read ports
module if_instr_mem #(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 512,
  parameter int INSTR_W = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [INSTR_W-1:0]         wr_data,
  input  logic [ISSUE_W*ADDR_W-1:0]  rd_addr,
  output logic [ISSUE_W*INSTR_W-1:0] rd_data
);

  // Contents deliberately survive reset so a program can be restarted.
  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_rd
    assign rd_data[g*INSTR_W +: INSTR_W] = mem[rd_addr[g*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch unit presenting aligned ISSUE_W-wide instruction groups to decode
module if_fetch_unit
  import spu_if_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 512,
  parameter int INSTR_W = INSTR_W_DEF,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PC_W   = ADDR_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_en,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic [INSTR_W-1:0]         load_data,
  input  logic                       start,
  input  logic [PC_W-1:0]            start_pc,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [ISSUE_W-1:0]         lane_valid,
  output logic [ISSUE_W*INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]            pc_out,
  output logic                       halted
);

  localparam logic [PC_W-1:0]    LANE_MASK  = PC_W'(ISSUE_W - 1);
  localparam logic [PC_W-1:0]    ISSUE_STEP = PC_W'(ISSUE_W);
  localparam logic [INSTR_W-1:0] NOP        = INSTR_W'(NOP_WORD);

  fetch_state_e               state_q, state_d;
  logic [PC_W-1:0]            pc_q, pc_d;
  logic [PC_W-1:0]            prog_end_q, prog_end_d;
  logic                       out_valid_q, out_valid_d;
  logic [ISSUE_W-1:0]         lane_valid_q, lane_valid_d;
  logic [ISSUE_W*INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]            pc_out_q, pc_out_d;
  logic                       halted_q, halted_d;

  logic                       mem_we;
  logic                       take_redirect;
  logic                       slot_free;
  logic [PC_W-1:0]            tgt_pc;
  logic [PC_W-1:0]            tgt_base;
  logic [PC_W-1:0]            lane_pc [ISSUE_W];
  logic [ISSUE_W*ADDR_W-1:0]  rd_addr;
  logic [ISSUE_W*INSTR_W-1:0] rd_data;
  logic [ISSUE_W-1:0]         grp_valid;
  logic [ISSUE_W*INSTR_W-1:0] grp_data;

  // A redirect replaces whatever group is pending, so it also picks the read address.
  assign take_redirect = (state_q == ST_RUN) && redirect_valid;
  assign slot_free     = !out_valid_q || out_ready;
  assign tgt_pc        = take_redirect ? redirect_pc : pc_q;
  assign tgt_base      = tgt_pc & ~LANE_MASK;

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
    assign lane_pc[g]                    = tgt_base + PC_W'(g);
    assign rd_addr[g*ADDR_W +: ADDR_W]   = lane_pc[g][ADDR_W-1:0];
  end

  if_instr_mem #(
    .ISSUE_W (ISSUE_W),
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Lane 0 (lowest address) sits in the MSBs of both lane_valid and instr_out.
  always_comb begin
    grp_valid = '0;
    grp_data  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (lane_pc[i] >= tgt_pc && lane_pc[i] < prog_end_q) begin
        grp_valid[ISSUE_W-1-i]                   = 1'b1;
        grp_data[(ISSUE_W-1-i)*INSTR_W +: INSTR_W] = rd_data[i*INSTR_W +: INSTR_W];
      end else begin
        grp_data[(ISSUE_W-1-i)*INSTR_W +: INSTR_W] = NOP;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    prog_end_d   = prog_end_q;
    out_valid_d  = out_valid_q;
    lane_valid_d = lane_valid_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    mem_we       = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (load_en) begin
          mem_we = 1'b1;
          if (PC_W'(load_addr) >= prog_end_q) begin
            prog_end_d = PC_W'(load_addr) + 1'b1;
          end
        end
        if (start) begin
          state_d = ST_RUN;
          pc_d    = start_pc;
        end
      end
      ST_RUN: begin
        if (take_redirect || slot_free) begin
          if (tgt_pc >= prog_end_q) begin
            out_valid_d  = 1'b0;
            lane_valid_d = '0;
            state_d      = ST_HALT;
          end else begin
            out_valid_d  = 1'b1;
            lane_valid_d = grp_valid;
            instr_d      = grp_data;
            pc_out_d     = tgt_base;
            pc_d         = tgt_base + ISSUE_STEP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      prog_end_q   <= '0;
      out_valid_q  <= 1'b0;
      lane_valid_q <= '0;
      instr_q      <= '0;
      pc_out_q     <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      prog_end_q   <= prog_end_d;
      out_valid_q  <= out_valid_d;
      lane_valid_q <= lane_valid_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      halted_q     <= halted_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign lane_valid = lane_valid_q;
  assign instr_out  = instr_q;
  assign pc_out     = pc_out_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
  import spu_if_pkg::*;

  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 64;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 6;
  localparam int PC_W    = 7;
  localparam int GW      = ISSUE_W * INSTR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [INSTR_W-1:0] load_data = '0;
  logic              start = 1'b0;
  logic [PC_W-1:0]   start_pc = '0;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [ISSUE_W-1:0] lane_valid;
  logic [GW-1:0]     instr_out;
  logic [PC_W-1:0]   pc_out;
  logic              halted;

  int n_pass  = 0;
  int n_total = 0;

  logic [INSTR_W-1:0] m_mem [DEPTH];

  typedef struct {
    logic            st;
    logic [PC_W-1:0] spc;
    logic            rdy;
    logic            rv;
    logic [PC_W-1:0] rpc;
    logic            ev;
    logic [PC_W-1:0] epc;
    logic [1:0]      elv;
    logic            eh;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  if_fetch_unit #(
    .ISSUE_W (ISSUE_W),
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .start          (start),
    .start_pc       (start_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .lane_valid     (lane_valid),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .halted         (halted)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [INSTR_W-1:0] d);
    load_en   = 1'b1;
    load_addr = ADDR_W'(a);
    load_data = d;
    step();
    load_en   = 1'b0;
    m_mem[a]  = d;
  endtask

  // Expected group contents from the bench's own copy of the buffer.
  function automatic logic [GW-1:0] exp_instr(input int base, input logic [1:0] lv);
    logic [GW-1:0] r;
    r = '0;
    for (int i = 0; i < ISSUE_W; i++)
      r[(ISSUE_W-1-i)*INSTR_W +: INSTR_W] = lv[ISSUE_W-1-i] ? m_mem[base+i] : NOP_WORD;
    return r;
  endfunction

  function automatic vec_t mk(input int st, input int spc, input int rdy, input int rv, input int rpc,
                              input int ev, input int epc, input int elv, input int eh);
    vec_t v;
    v.st = st[0]; v.spc = PC_W'(spc); v.rdy = rdy[0]; v.rv = rv[0]; v.rpc = PC_W'(rpc);
    v.ev = ev[0]; v.epc = PC_W'(epc); v.elv = elv[1:0]; v.eh = eh[0];
    return v;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " lane_valid"}, 64'(lane_valid), 64'd0);
    check({tag, " instr_out"}, 64'(instr_out), 64'd0);
    check({tag, " pc_out"}, 64'(pc_out), 64'd0);
    check({tag, " halted"}, 64'(halted), 64'd0);
  endtask

  task automatic check_grp(input string tag, input int epc, input logic [1:0] elv);
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " pc_out"}, 64'(pc_out), 64'(epc));
    check({tag, " lane_valid"}, 64'(lane_valid), 64'(elv));
    check({tag, " instr_out"}, 64'(instr_out), 64'(exp_instr(epc, elv)));
  endtask

  // Reference model state: running flag, pc, program end and the expected presented group.
  bit            m_run, m_halted, e_valid;
  int            m_pc, m_prog_end, e_pc;
  logic [1:0]    e_lv;
  logic [GW-1:0] e_instr;

  task automatic model_step();
    int tgt, base;
    if (!m_run) begin
      if (load_en) begin
        m_mem[int'(load_addr)] = load_data;
        if (int'(load_addr) + 1 > m_prog_end) m_prog_end = int'(load_addr) + 1;
      end
      if (start) begin
        m_run = 1; m_halted = 0; m_pc = int'(start_pc);
      end
    end else if (redirect_valid || !e_valid || out_ready) begin
      tgt = redirect_valid ? int'(redirect_pc) : m_pc;
      if (tgt >= m_prog_end) begin
        e_valid = 0; m_run = 0; m_halted = 1;
      end else begin
        base = (tgt / ISSUE_W) * ISSUE_W;
        e_valid = 1; e_pc = base; e_lv = '0; e_instr = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
          if (base + i >= tgt && base + i < m_prog_end) begin
            e_lv[ISSUE_W-1-i] = 1'b1;
            e_instr[(ISSUE_W-1-i)*INSTR_W +: INSTR_W] = m_mem[base+i];
          end else begin
            e_instr[(ISSUE_W-1-i)*INSTR_W +: INSTR_W] = NOP_WORD;
          end
        end
        m_pc = base + ISSUE_W;
      end
    end
  endtask

  initial begin
    // Fetch sequences starting from a buffer holding addresses 0..7.
    vecs.push_back(mk(1,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,1,0,0, 1,2,3,0));
    vecs.push_back(mk(0,0,1,0,0, 1,4,3,0));
    vecs.push_back(mk(0,0,1,0,0, 1,6,3,0));
    vecs.push_back(mk(0,0,1,0,0, 0,0,0,1));
    vecs.push_back(mk(1,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,1,0,0, 1,2,3,0));
    vecs.push_back(mk(0,0,0,0,0, 1,2,3,0));
    vecs.push_back(mk(0,0,0,0,0, 1,2,3,0));
    vecs.push_back(mk(0,0,0,0,0, 1,2,3,0));
    vecs.push_back(mk(0,0,1,0,0, 1,4,3,0));
    vecs.push_back(mk(0,0,1,0,0, 1,6,3,0));
    vecs.push_back(mk(0,0,1,0,0, 0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,0,1,5, 1,4,1,0));
    vecs.push_back(mk(0,0,1,0,0, 1,6,3,0));
    vecs.push_back(mk(0,0,1,0,0, 0,0,0,1));
    vecs.push_back(mk(1,3,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,2,1,0));
    vecs.push_back(mk(0,0,0,1,8, 0,0,0,1));
    vecs.push_back(mk(0,0,1,1,0, 0,0,0,1));
    vecs.push_back(mk(1,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,0,3,0));
    vecs.push_back(mk(1,6,1,0,0, 1,2,3,0));
    vecs.push_back(mk(0,0,1,0,0, 1,4,3,0));
    vecs.push_back(mk(0,0,1,0,0, 1,6,3,0));
    vecs.push_back(mk(0,0,1,0,0, 0,0,0,1));

    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    for (int a = 0; a < 8; a++) load(a, 32'hC0DE_0000 + INSTR_W'(a));

    foreach (vecs[k]) begin
      start          = vecs[k].st;
      start_pc       = vecs[k].spc;
      out_ready      = vecs[k].rdy;
      redirect_valid = vecs[k].rv;
      redirect_pc    = vecs[k].rpc;
      step();
      start = 1'b0; redirect_valid = 1'b0;
      check($sformatf("vec%0d out_valid", k), 64'(out_valid), 64'(vecs[k].ev));
      check($sformatf("vec%0d halted", k), 64'(halted), 64'(vecs[k].eh));
      if (vecs[k].ev) begin
        check($sformatf("vec%0d pc_out", k), 64'(pc_out), 64'(vecs[k].epc));
        check($sformatf("vec%0d lane_valid", k), 64'(lane_valid), 64'(vecs[k].elv));
        check($sformatf("vec%0d instr_out", k), 64'(instr_out), 64'(exp_instr(int'(vecs[k].epc), vecs[k].elv)));
      end
    end

    // Reset in the middle of a run, then restart with the buffer kept but prog_end cleared.
    start = 1'b1; start_pc = '0; out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    check_grp("prereset", 0, 2'b11);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    step();
    check_zero("held_reset");
    rst_n = 1'b1;
    step();
    start = 1'b1; start_pc = PC_W'(2);
    step();
    start = 1'b0;
    step();
    check("empty_prog out_valid", 64'(out_valid), 64'd0);
    check("empty_prog halted", 64'(halted), 64'd1);
    load(4, 32'h5A5A_0004);
    start = 1'b1; start_pc = PC_W'(2);
    step();
    start = 1'b0;
    step();
    check_grp("restart pc2", 2, 2'b11);
    step();
    check_grp("tail pc4", 4, 2'b10);
    step();
    check("tail out_valid", 64'(out_valid), 64'd0);
    check("tail halted", 64'(halted), 64'd1);

    // Randomised run against the reference model, buffer fully known first.
    for (int a = 0; a < DEPTH; a++) load(a, $urandom);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    m_run = 0; m_halted = 0; e_valid = 0; m_pc = 0; m_prog_end = 0; e_pc = 0;
    e_lv = '0; e_instr = '0;
    for (int c = 0; c < 3000; c++) begin
      load_en        = ($urandom % 4) == 0;
      load_addr      = ADDR_W'($urandom_range(0, 47));
      load_data      = $urandom;
      start          = m_run ? (($urandom % 20) == 0) : (($urandom % 3) == 0);
      start_pc       = PC_W'($urandom_range(0, 50));
      out_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 10) == 0;
      redirect_pc    = PC_W'($urandom_range(0, 52));
      model_step();
      step();
      check($sformatf("rnd%0d out_valid", c), 64'(out_valid), 64'(e_valid));
      check($sformatf("rnd%0d halted", c), 64'(halted), 64'(m_halted));
      if (e_valid) begin
        check($sformatf("rnd%0d pc_out", c), 64'(pc_out), 64'(e_pc));
        check($sformatf("rnd%0d lane_valid", c), 64'(lane_valid), 64'(e_lv));
        check($sformatf("rnd%0d instr_out", c), 64'(instr_out), 64'(e_instr));
      end
    end
    load_en = 1'b0; start = 1'b0; redirect_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
